// File: rtl/tri_chk.sv
// Trapezoid waveform checker: follows each 0 -> ramp up -> plateau -> ramp down -> 0
// period and reports the plateau level and segment lengths of the last complete one.
module tri_chk #(
  parameter int DATA_W = 9,
  parameter int LEN_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic [DATA_W-1:0] d_in,
  input  logic              d_vld,
  output logic [1:0]        phase,
  output logic [DATA_W-1:0] peak,
  output logic [LEN_W-1:0]  rise_len,
  output logic [LEN_W-1:0]  flat_len,
  output logic [LEN_W-1:0]  fall_len,
  output logic [CNT_W-1:0]  per_cnt,
  output logic              per_done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RISE, S_FLAT, S_FALL} state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_RISE = 2'd1;
  localparam logic [1:0] PH_FLAT = 2'd2;
  localparam logic [1:0] PH_FALL = 2'd3;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] v);
    return (v == {LEN_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t              state;
  logic [DATA_W-1:0]   p;
  logic [DATA_W-1:0]   w_peak;
  logic [LEN_W-1:0]    w_rise, w_flat, w_fall;

  // Two spare bits keep p+1 and p-1 out of range of any legal sample instead of wrapping
  logic signed [DATA_W+1:0] d_s, p_s;
  logic is_zero, is_one, up, same, dn, p_one, viol;

  assign d_s     = signed'({2'b00, d_in});
  assign p_s     = signed'({2'b00, p});
  assign is_zero = (d_s == 0);
  assign is_one  = (d_s == 1);
  assign p_one   = (p_s == 1);
  assign up      = (d_s == p_s + 1);
  assign same    = (d_s == p_s);
  assign dn      = (d_s == p_s - 1);

  always_comb begin
    viol = 1'b0;
    unique case (state)
      S_IDLE:  viol = 1'b0;
      S_ARM:   viol = !is_zero && !is_one;
      S_RISE:  viol = !up && !same;
      S_FLAT:  viol = !same && !dn;
      S_FALL:  viol = !(dn && !is_zero) && !(is_zero && p_one);
      default: viol = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= S_IDLE;
      phase    <= PH_IDLE;
      p        <= '0;
      w_peak   <= '0;
      w_rise   <= '0;
      w_flat   <= '0;
      w_fall   <= '0;
      peak     <= '0;
      rise_len <= '0;
      flat_len <= '0;
      fall_len <= '0;
      per_cnt  <= '0;
      per_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      per_done <= 1'b0;
      err      <= 1'b0;
      if (d_vld) begin
        p <= d_in;
        if (viol) begin
          err    <= 1'b1;
          w_peak <= '0;
          w_rise <= '0;
          w_flat <= '0;
          w_fall <= '0;
          state  <= is_zero ? S_ARM : S_IDLE;
          phase  <= PH_IDLE;
        end else begin
          unique case (state)
            S_IDLE: if (is_zero) state <= S_ARM;
            S_ARM: if (is_one) begin
              state  <= S_RISE;
              phase  <= PH_RISE;
              w_rise <= LEN_W'(1);
            end
            S_RISE: if (up) begin
              w_rise <= sat_len(w_rise);
            end else begin
              state  <= S_FLAT;
              phase  <= PH_FLAT;
              w_peak <= p;
              w_flat <= LEN_W'(1);
            end
            S_FLAT: if (same) begin
              w_flat <= sat_len(w_flat);
            end else begin
              state  <= S_FALL;
              phase  <= PH_FALL;
              w_fall <= LEN_W'(1);
            end
            S_FALL: if (is_zero) begin
              // The closing 0 is itself the last -1 step of the fall
              state    <= S_ARM;
              phase    <= PH_IDLE;
              peak     <= w_peak;
              rise_len <= w_rise;
              flat_len <= w_flat;
              fall_len <= sat_len(w_fall);
              per_cnt  <= sat_cnt(per_cnt);
              per_done <= 1'b1;
              w_peak   <= '0;
              w_rise   <= '0;
              w_flat   <= '0;
              w_fall   <= '0;
            end else begin
              w_fall <= sat_len(w_fall);
            end
            default: begin
              state <= S_IDLE;
              phase <= PH_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_chk.sv
// Directed bench for tri_chk: full trapezoid periods, gapped input, shape violations and reset.
module tb_tri_chk;

  logic       clk = 1'b0;
  logic       res;
  logic [8:0] d_in;
  logic       d_vld;
  logic [1:0] phase;
  logic [8:0] peak;
  logic [9:0] rise_len, flat_len, fall_len;
  logic [15:0] per_cnt;
  logic       per_done, err;

  int n_chk  = 0;
  int n_fail = 0;
  int err_seen, done_seen, gap_bad;

  tri_chk dut (
    .clk(clk), .res(res), .d_in(d_in), .d_vld(d_vld),
    .phase(phase), .peak(peak), .rise_len(rise_len), .flat_len(flat_len),
    .fall_len(fall_len), .per_cnt(per_cnt), .per_done(per_done), .err(err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input, then let outputs settle #1 after the edge
  task automatic step(input int v, input logic vld, input logic r);
    @(negedge clk);
    d_in  = 9'(v);
    d_vld = vld;
    res   = r;
    @(posedge clk);
    #1;
    err_seen  += int'(err);
    done_seen += int'(per_done);
  endtask

  task automatic do_reset();
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0);
    err_seen = 0; done_seen = 0; gap_bad = 0;
  endtask

  // Valid sample followed optionally by an idle cycle in which every output must hold
  task automatic sample(input int v, input bit gap);
    logic [63:0] snap;
    step(v, 1'b1, 1'b0);
    if (gap) begin
      snap = {phase, peak, rise_len, flat_len, fall_len, per_cnt};
      step(511, 1'b0, 1'b0);
      if (snap !== {phase, peak, rise_len, flat_len, fall_len, per_cnt} || per_done || err)
        gap_bad++;
    end
  endtask

  task automatic send_period(input bit gap);
    sample(0, gap);
    for (int v = 1; v <= 300; v++) sample(v, gap);
    for (int i = 0; i < 201; i++) sample(300, gap);
    for (int v = 299; v >= 1; v--) sample(v, gap);
    step(0, 1'b1, 1'b0);
  endtask

  task automatic check_results(input string tag, input int pc);
    n_chk++; if (peak !== 9'd300) begin n_fail++; $display("FAIL %s peak: got %0d want 300", tag, peak); end
    n_chk++; if (rise_len !== 10'd300) begin n_fail++; $display("FAIL %s rise_len: got %0d want 300", tag, rise_len); end
    n_chk++; if (flat_len !== 10'd201) begin n_fail++; $display("FAIL %s flat_len: got %0d want 201", tag, flat_len); end
    n_chk++; if (fall_len !== 10'd300) begin n_fail++; $display("FAIL %s fall_len: got %0d want 300", tag, fall_len); end
    n_chk++; if (per_cnt !== 16'(pc)) begin n_fail++; $display("FAIL %s per_cnt: got %0d want %0d", tag, per_cnt, pc); end
    n_chk++; if (err_seen !== 0) begin n_fail++; $display("FAIL %s err pulses: got %0d want 0", tag, err_seen); end
    n_chk++; if (done_seen !== pc) begin n_fail++; $display("FAIL %s per_done pulses: got %0d want %0d", tag, done_seen, pc); end
  endtask

  task automatic test_reset();
    step(5, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    n_chk++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset phase: got %0d want 0", phase); end
    n_chk++; if ({peak, rise_len, flat_len, fall_len} !== '0) begin n_fail++; $display("FAIL reset results: got %h want 0", {peak, rise_len, flat_len, fall_len}); end
    n_chk++; if (per_cnt !== 16'd0) begin n_fail++; $display("FAIL reset per_cnt: got %0d want 0", per_cnt); end
    n_chk++; if ({per_done, err} !== 2'b00) begin n_fail++; $display("FAIL reset pulses: got %b want 00", {per_done, err}); end
  endtask

  task automatic test_period();
    do_reset();
    send_period(1'b0);
    n_chk++; if (per_done !== 1'b1) begin n_fail++; $display("FAIL period per_done after last 0: got %b want 1", per_done); end
    n_chk++; if (phase !== 2'd0) begin n_fail++; $display("FAIL period phase: got %0d want 0", phase); end
    check_results("period", 1);
    step(0, 1'b1, 1'b0);
    n_chk++; if (per_done !== 1'b0) begin n_fail++; $display("FAIL period per_done width: got %b want 0", per_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_period(1'b0);
    send_period(1'b0);
    check_results("b2b", 2);
  endtask

  task automatic test_gaps();
    do_reset();
    send_period(1'b1);
    n_chk++; if (per_done !== 1'b1) begin n_fail++; $display("FAIL gaps per_done: got %b want 1", per_done); end
    check_results("gaps", 1);
    step(0, 1'b0, 1'b0);
    n_chk++; if (gap_bad !== 0 || per_done !== 1'b0 || per_cnt !== 16'd1) begin
      n_fail++; $display("FAIL gaps hold: got bad=%0d done=%b cnt=%0d want 0/0/1", gap_bad, per_done, per_cnt);
    end
  endtask

  task automatic test_violation();
    do_reset();
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0); step(2, 1'b1, 1'b0); step(3, 1'b1, 1'b0);
    n_chk++; if (phase !== 2'd1 || err !== 1'b0) begin n_fail++; $display("FAIL viol rise phase/err: got %0d/%b want 1/0", phase, err); end
    step(5, 1'b1, 1'b0);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL viol err: got %b want 1", err); end
    n_chk++; if (phase !== 2'd0 || per_cnt !== 16'd0) begin n_fail++; $display("FAIL viol state: got phase=%0d cnt=%0d want 0/0", phase, per_cnt); end
    step(1, 1'b1, 1'b0);
    n_chk++; if (phase !== 2'd0 || err !== 1'b0) begin n_fail++; $display("FAIL viol idle hold: got %0d/%b want 0/0", phase, err); end
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    n_chk++; if (phase !== 2'd1) begin n_fail++; $display("FAIL viol rearm: got phase %0d want 1", phase); end
  endtask

  task automatic test_period_then_err();
    do_reset();
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0); step(2, 1'b1, 1'b0); step(2, 1'b1, 1'b0);
    n_chk++; if (phase !== 2'd2) begin n_fail++; $display("FAIL small flat phase: got %0d want 2", phase); end
    step(1, 1'b1, 1'b0);
    n_chk++; if (phase !== 2'd3) begin n_fail++; $display("FAIL small fall phase: got %0d want 3", phase); end
    step(0, 1'b1, 1'b0);
    n_chk++; if (per_done !== 1'b1 || per_cnt !== 16'd1) begin n_fail++; $display("FAIL small accept: got done=%b cnt=%0d want 1/1", per_done, per_cnt); end
    n_chk++; if ({peak, rise_len, flat_len, fall_len} !== {9'd2, 10'd2, 10'd1, 10'd2}) begin
      n_fail++; $display("FAIL small results: got %0d/%0d/%0d/%0d want 2/2/1/2", peak, rise_len, flat_len, fall_len);
    end
    step(0, 1'b1, 1'b0); step(1, 1'b1, 1'b0); step(2, 1'b1, 1'b0); step(3, 1'b1, 1'b0); step(3, 1'b1, 1'b0);
    n_chk++; if (err_seen !== 0) begin n_fail++; $display("FAIL small early err: got %0d want 0", err_seen); end
    step(4, 1'b1, 1'b0);
    n_chk++; if (err !== 1'b1 || phase !== 2'd0) begin n_fail++; $display("FAIL small flat viol: got err=%b phase=%0d want 1/0", err, phase); end
    n_chk++; if (peak !== 9'd2 || per_cnt !== 16'd1 || fall_len !== 10'd2) begin
      n_fail++; $display("FAIL small hold after err: got peak=%0d cnt=%0d fall=%0d want 2/1/2", peak, per_cnt, fall_len);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_period(1'b0);
    step(0, 1'b1, 1'b0);
    for (int v = 1; v <= 5; v++) step(v, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0); step(5, 1'b1, 1'b0);
    n_chk++; if (phase !== 2'd2) begin n_fail++; $display("FAIL mid flat phase: got %0d want 2", phase); end
    step(5, 1'b1, 1'b1);
    n_chk++; if ({phase, peak, rise_len, flat_len, fall_len, per_cnt, per_done, err} !== '0) begin
      n_fail++; $display("FAIL mid reset outputs: got phase=%0d peak=%0d cnt=%0d want all 0", phase, peak, per_cnt);
    end
    err_seen = 0; done_seen = 0;
    send_period(1'b0);
    check_results("after reset", 1);
  endtask

  initial begin
    res = 1'b1; d_in = '0; d_vld = 1'b0;
    err_seen = 0; done_seen = 0; gap_bad = 0;
    test_reset();
    test_period();
    test_back_to_back();
    test_gaps();
    test_violation();
    test_period_then_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
